// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl
//   Match sequencer for the Pong top level. It owns the serve / play / point /
//   game-over flow and both player score counters. It also gates the ball
//   datapath and strobes the two score displays. Serve and point delays are
//   counted in whole video frames, one frame per falling edge of vsync.
//
// Ports
//   clk            in   pixel clock, single clock domain
//   reset          in   synchronous active-high reset
//   vsync          in   VGA vertical sync, active-low
//   start          in   debounced serve/new-game request (level)
//   miss_left      in   pulse: ball left the screen on the left (P1 missed)
//   miss_right     in   pulse: ball left the screen on the right (P2 missed)
//   ball_run       out  ball may move
//   ball_center    out  hold ball at screen centre
//   serve_dir      out  0 = launch leftward, 1 = launch rightward
//   p1_score_pulse out  one-cycle increment strobe, player-1 display
//   p2_score_pulse out  one-cycle increment strobe, player-2 display
//   p1_score       out  player-1 points
//   p2_score       out  player-2 points
//   game_over      out  match finished
//   winner         out  0 = player 1, 1 = player 2 (valid with game_over)
//   state          out  current state encoding (debug)
module pong_game_ctrl #(
  parameter int WIN_SCORE    = 9,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90,
  parameter int SCORE_W      = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               vsync,
  input  logic               start,
  input  logic               miss_left,
  input  logic               miss_right,
  output logic               ball_run,
  output logic               ball_center,
  output logic               serve_dir,
  output logic               p1_score_pulse,
  output logic               p2_score_pulse,
  output logic [SCORE_W-1:0] p1_score,
  output logic [SCORE_W-1:0] p2_score,
  output logic               game_over,
  output logic               winner,
  output logic [2:0]         state
);

  localparam int MAX_FRAMES = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
  localparam int CNT_W      = $clog2(MAX_FRAMES + 1);

  localparam logic [CNT_W-1:0]   SERVE_LOAD = CNT_W'(SERVE_FRAMES);
  localparam logic [CNT_W-1:0]   POINT_LOAD = CNT_W'(POINT_FRAMES);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
  localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] SCORE_ONE  = SCORE_W'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    POINT = 3'd3,
    OVER  = 3'd4
  } state_t;

  // Registered state and outputs
  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_vsync_d;
  logic               r_start_d;
  logic [SCORE_W-1:0] r_p1_score;
  logic [SCORE_W-1:0] r_p2_score;
  logic               r_p1_pulse;
  logic               r_p2_pulse;
  logic               r_serve_dir;
  logic               r_game_over;
  logic               r_winner;
  logic               r_ball_run;
  logic               r_ball_center;

  // Next-state values
  state_t             w_state;
  logic [CNT_W-1:0]   w_cnt;
  logic [SCORE_W-1:0] w_p1_score;
  logic [SCORE_W-1:0] w_p2_score;
  logic [SCORE_W-1:0] w_p1_inc;
  logic [SCORE_W-1:0] w_p2_inc;
  logic               w_p1_pulse;
  logic               w_p2_pulse;
  logic               w_serve_dir;
  logic               w_game_over;
  logic               w_winner;
  logic               w_frame_tick;
  logic               w_start_edge;

  // One tick per frame, on the falling edge of the active-low vsync.
  assign w_frame_tick = r_vsync_d & ~vsync;
  // start_d resets high, so a start held through reset does not count as an edge.
  assign w_start_edge = start & ~r_start_d;

  assign w_p1_inc = r_p1_score + SCORE_ONE;
  assign w_p2_inc = r_p2_score + SCORE_ONE;

  always_comb begin
    w_state     = r_state;
    w_cnt       = r_cnt;
    w_p1_score  = r_p1_score;
    w_p2_score  = r_p2_score;
    w_p1_pulse  = 1'b0;
    w_p2_pulse  = 1'b0;
    w_serve_dir = r_serve_dir;
    w_game_over = r_game_over;
    w_winner    = r_winner;

    case (r_state)
      IDLE: begin
        if (w_start_edge) begin
          w_state = SERVE;
          w_cnt   = SERVE_LOAD;
        end
      end

      SERVE: begin
        if (w_frame_tick) begin
          if (r_cnt == CNT_ONE) w_state = PLAY;
          else                  w_cnt   = r_cnt - CNT_ONE;
        end
      end

      PLAY: begin
        // A simultaneous miss_right is dropped when miss_left is present.
        if (miss_left) begin
          w_p2_score  = w_p2_inc;
          w_p2_pulse  = 1'b1;
          w_serve_dir = 1'b0;
          if (w_p2_inc == WIN_VAL) begin
            w_state     = OVER;
            w_game_over = 1'b1;
            w_winner    = 1'b1;
          end else begin
            w_state = POINT;
            w_cnt   = POINT_LOAD;
          end
        end else if (miss_right) begin
          w_p1_score  = w_p1_inc;
          w_p1_pulse  = 1'b1;
          w_serve_dir = 1'b1;
          if (w_p1_inc == WIN_VAL) begin
            w_state     = OVER;
            w_game_over = 1'b1;
            w_winner    = 1'b0;
          end else begin
            w_state = POINT;
            w_cnt   = POINT_LOAD;
          end
        end
      end

      POINT: begin
        if (w_frame_tick) begin
          if (r_cnt == CNT_ONE) begin
            w_state = SERVE;
            w_cnt   = SERVE_LOAD;
          end else begin
            w_cnt = r_cnt - CNT_ONE;
          end
        end
      end

      OVER: begin
        // New match: serve_dir is kept so the loser of the last point serves.
        if (w_start_edge) begin
          w_p1_score  = '0;
          w_p2_score  = '0;
          w_game_over = 1'b0;
          w_state     = SERVE;
          w_cnt       = SERVE_LOAD;
        end
      end

      default: begin
        w_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_vsync_d     <= 1'b1;
      r_start_d     <= 1'b1;
      r_p1_score    <= '0;
      r_p2_score    <= '0;
      r_p1_pulse    <= 1'b0;
      r_p2_pulse    <= 1'b0;
      r_serve_dir   <= 1'b0;
      r_game_over   <= 1'b0;
      r_winner      <= 1'b0;
      r_ball_run    <= 1'b0;
      r_ball_center <= 1'b1;
    end else begin
      r_state       <= w_state;
      r_cnt         <= w_cnt;
      r_vsync_d     <= vsync;
      r_start_d     <= start;
      r_p1_score    <= w_p1_score;
      r_p2_score    <= w_p2_score;
      r_p1_pulse    <= w_p1_pulse;
      r_p2_pulse    <= w_p2_pulse;
      r_serve_dir   <= w_serve_dir;
      r_game_over   <= w_game_over;
      r_winner      <= w_winner;
      // Ball gating follows the state being entered, so it lines up with state.
      r_ball_run    <= (w_state == PLAY);
      r_ball_center <= (w_state != PLAY);
    end
  end

  assign ball_run       = r_ball_run;
  assign ball_center    = r_ball_center;
  assign serve_dir      = r_serve_dir;
  assign p1_score_pulse = r_p1_pulse;
  assign p2_score_pulse = r_p2_pulse;
  assign p1_score       = r_p1_score;
  assign p2_score       = r_p2_score;
  assign game_over      = r_game_over;
  assign winner         = r_winner;
  assign state          = r_state;

endmodule

// File: tb/tb_pong_game_ctrl.sv
module tb_pong_game_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       vsync = 1'b1;
  logic       start = 1'b0;
  logic       miss_left = 1'b0;
  logic       miss_right = 1'b0;
  logic       ball_run;
  logic       ball_center;
  logic       serve_dir;
  logic       p1_score_pulse;
  logic       p2_score_pulse;
  logic [3:0] p1_score;
  logic [3:0] p2_score;
  logic       game_over;
  logic       winner;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  pong_game_ctrl #(
    .WIN_SCORE(3),
    .SERVE_FRAMES(2),
    .POINT_FRAMES(3),
    .SCORE_W(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .vsync(vsync),
    .start(start),
    .miss_left(miss_left),
    .miss_right(miss_right),
    .ball_run(ball_run),
    .ball_center(ball_center),
    .serve_dir(serve_dir),
    .p1_score_pulse(p1_score_pulse),
    .p2_score_pulse(p2_score_pulse),
    .p1_score(p1_score),
    .p2_score(p2_score),
    .game_over(game_over),
    .winner(winner),
    .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One video frame: vsync low for one cycle gives exactly one frame tick.
  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      vsync = 1'b0;
      step();
      vsync = 1'b1;
      step();
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b1;
    step(3);
    reset = 1'b0;
    step(2);
    checks++;
    if ({state, ball_run, ball_center} !== {3'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_idle: state/run/center=%0d/%b/%b want 0/0/1", state, ball_run, ball_center);
    end
    checks++;
    if ({p1_score, p2_score, game_over, winner, serve_dir} !== {4'd0, 4'd0, 3'b000}) begin
      errors++;
      $display("FAIL reset_regs: p1=%0d p2=%0d go=%b win=%b dir=%b want zeros",
               p1_score, p2_score, game_over, winner, serve_dir);
    end
  endtask

  task automatic test_start_serve;
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    checks++;
    if ({state, ball_run, ball_center} !== {3'd1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL start_serve: state/run/center=%0d/%b/%b want 1/0/1", state, ball_run, ball_center);
    end
    start = 1'b0;
    frames(1);
    checks++;
    if (state !== 3'd1) begin
      errors++;
      $display("FAIL serve_hold: state=%0d want 1", state);
    end
    frames(1);
    checks++;
    if ({state, ball_run, ball_center} !== {3'd2, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL serve_to_play: state/run/center=%0d/%b/%b want 2/1/0", state, ball_run, ball_center);
    end
  endtask

  task automatic test_miss_right;
    miss_right = 1'b1;
    step();
    miss_right = 1'b0;
    checks++;
    if ({p1_score, p1_score_pulse, p2_score_pulse, serve_dir, state} !== {4'd1, 1'b1, 1'b0, 1'b1, 3'd3}) begin
      errors++;
      $display("FAIL miss_right: p1=%0d pl1=%b pl2=%b dir=%b st=%0d want 1/1/0/1/3",
               p1_score, p1_score_pulse, p2_score_pulse, serve_dir, state);
    end
    step();
    checks++;
    if ({p1_score_pulse, ball_run, ball_center} !== 3'b001) begin
      errors++;
      $display("FAIL pulse_width: pl1=%b run=%b center=%b want 0/0/1", p1_score_pulse, ball_run, ball_center);
    end
    frames(2);
    checks++;
    if (state !== 3'd3) begin
      errors++;
      $display("FAIL point_hold: state=%0d want 3", state);
    end
    frames(1);
    checks++;
    if (state !== 3'd1) begin
      errors++;
      $display("FAIL point_to_serve: state=%0d want 1", state);
    end
    frames(2);
    checks++;
    if (state !== 3'd2) begin
      errors++;
      $display("FAIL reserve_to_play: state=%0d want 2", state);
    end
  endtask

  task automatic test_simultaneous_miss;
    miss_left = 1'b1;
    miss_right = 1'b1;
    step();
    miss_left = 1'b0;
    miss_right = 1'b0;
    checks++;
    if ({p1_score, p2_score, p1_score_pulse, p2_score_pulse, serve_dir, state} !==
        {4'd1, 4'd1, 1'b0, 1'b1, 1'b0, 3'd3}) begin
      errors++;
      $display("FAIL simultaneous: p1=%0d p2=%0d pl1=%b pl2=%b dir=%b st=%0d want 1/1/0/1/0/3",
               p1_score, p2_score, p1_score_pulse, p2_score_pulse, serve_dir, state);
    end
  endtask

  task automatic test_ignored_misses;
    // Currently in POINT
    miss_left = 1'b1;
    step();
    miss_left = 1'b0;
    checks++;
    if ({p1_score, p2_score, p1_score_pulse, p2_score_pulse, state} !== {4'd1, 4'd1, 1'b0, 1'b0, 3'd3}) begin
      errors++;
      $display("FAIL miss_in_point: p1=%0d p2=%0d pl1=%b pl2=%b st=%0d want 1/1/0/0/3",
               p1_score, p2_score, p1_score_pulse, p2_score_pulse, state);
    end
    frames(3);
    miss_left = 1'b1;
    step();
    miss_left = 1'b0;
    checks++;
    if ({p1_score, p2_score, p1_score_pulse, p2_score_pulse, state} !== {4'd1, 4'd1, 1'b0, 1'b0, 3'd1}) begin
      errors++;
      $display("FAIL miss_in_serve: p1=%0d p2=%0d pl1=%b pl2=%b st=%0d want 1/1/0/0/1",
               p1_score, p2_score, p1_score_pulse, p2_score_pulse, state);
    end
    frames(2);
    checks++;
    if (state !== 3'd2) begin
      errors++;
      $display("FAIL back_to_play: state=%0d want 2", state);
    end
  endtask

  task automatic test_game_over;
    miss_left = 1'b1;
    step();
    miss_left = 1'b0;
    checks++;
    if ({p2_score, state, game_over} !== {4'd2, 3'd3, 1'b0}) begin
      errors++;
      $display("FAIL second_point: p2=%0d st=%0d go=%b want 2/3/0", p2_score, state, game_over);
    end
    frames(5);
    miss_left = 1'b1;
    step();
    miss_left = 1'b0;
    checks++;
    if ({p2_score, state, game_over, winner, p2_score_pulse, ball_run, ball_center} !==
        {4'd3, 3'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL win: p2=%0d st=%0d go=%b win=%b pl2=%b run=%b ctr=%b want 3/4/1/1/1/0/1",
               p2_score, state, game_over, winner, p2_score_pulse, ball_run, ball_center);
    end
    miss_left = 1'b1;
    step();
    miss_left = 1'b0;
    miss_right = 1'b1;
    step();
    miss_right = 1'b0;
    checks++;
    if ({p1_score_pulse, p2_score_pulse} !== 2'b00) begin
      errors++;
      $display("FAIL over_pulse: pl1=%b pl2=%b want 0/0", p1_score_pulse, p2_score_pulse);
    end
    frames(4);
    checks++;
    if ({p1_score, p2_score, state, game_over, winner} !== {4'd1, 4'd3, 3'd4, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL over_frozen: p1=%0d p2=%0d st=%0d go=%b win=%b want 1/3/4/1/1",
               p1_score, p2_score, state, game_over, winner);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if ({p1_score, p2_score, game_over, state, serve_dir} !== {4'd0, 4'd0, 1'b0, 3'd1, 1'b0}) begin
      errors++;
      $display("FAIL restart: p1=%0d p2=%0d go=%b st=%0d dir=%b want 0/0/0/1/0",
               p1_score, p2_score, game_over, state, serve_dir);
    end
  endtask

  task automatic test_reset_mid_point;
    frames(2);
    miss_right = 1'b1;
    step();
    miss_right = 1'b0;
    checks++;
    if ({state, p1_score, serve_dir} !== {3'd3, 4'd1, 1'b1}) begin
      errors++;
      $display("FAIL enter_point: st=%0d p1=%0d dir=%b want 3/1/1", state, p1_score, serve_dir);
    end
    frames(1);
    reset = 1'b1;
    step();
    checks++;
    if ({state, ball_run, ball_center, serve_dir, p1_score_pulse, p2_score_pulse,
         p1_score, p2_score, game_over, winner} !==
        {3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_point: st=%0d run=%b ctr=%b dir=%b p1=%0d p2=%0d go=%b win=%b",
               state, ball_run, ball_center, serve_dir, p1_score, p2_score, game_over, winner);
    end
    reset = 1'b0;
    frames(3);
    checks++;
    if (state !== 3'd0) begin
      errors++;
      $display("FAIL idle_after_reset: state=%0d want 0", state);
    end
  endtask

  initial begin
    test_reset();
    test_start_serve();
    test_miss_right();
    test_simultaneous_miss();
    test_ignored_misses();
    test_game_over();
    test_reset_mid_point();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
